// File: rtl/mmss_pkg.sv
// mmss_pkg -- shared types and constants for the MM:SS stopwatch.
//   state_t : control FSM states
//   bcd_t   : one BCD digit
//   *_MAX   : terminal values of the fixed-modulus digits
package mmss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_U_MAX = 4'd9;
    localparam bcd_t SEC_T_MAX = 4'd5;
    localparam bcd_t MIN_U_MAX = 4'd9;

    // Split a 0..99 minute limit into its tens / units BCD digits.
    function automatic bcd_t tens_of(input int unsigned v);
        return bcd_t'(v / 10);
    endfunction

    function automatic bcd_t units_of(input int unsigned v);
        return bcd_t'(v % 10);
    endfunction

endpackage

// File: rtl/mmss_timer_if.sv
// mmss_timer_if -- groups the stopwatch control inputs and display outputs.
//   tick, KEY_START, KEY_LAP, clr : stimulus into the timer
//   disp_*                        : four displayed BCD digits
//   running, lap_hold, wrap       : status
// master drives the inputs (prescaler/board side), slave is the timer.
interface mmss_timer_if;
    import mmss_pkg::*;

    logic tick;
    logic KEY_START;
    logic KEY_LAP;
    logic clr;
    bcd_t disp_sec_u;
    bcd_t disp_sec_t;
    bcd_t disp_min_u;
    bcd_t disp_min_t;
    logic running;
    logic lap_hold;
    logic wrap;

    modport master (
        output tick, KEY_START, KEY_LAP, clr,
        input  disp_sec_u, disp_sec_t, disp_min_u, disp_min_t,
        input  running, lap_hold, wrap
    );

    modport slave (
        input  tick, KEY_START, KEY_LAP, clr,
        output disp_sec_u, disp_sec_t, disp_min_u, disp_min_t,
        output running, lap_hold, wrap
    );

endinterface

// File: rtl/mmss_timer_bcd_digit_ctr.sv
// bcd_digit_ctr -- one BCD digit of the cascade.
//   clk, rst_n : clock, async active-low reset
//   en         : advance enable (carry of the lower digit)
//   clr        : synchronous clear, wins over en
//   digit      : current value, 0..MAX
//   carry      : en while sitting at MAX (combinational, ripples same cycle)
module bcd_digit_ctr
    import mmss_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output bcd_t digit,
    output logic carry
);

    bcd_t r_digit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else if (clr) begin
            r_digit <= '0;
        end else if (en) begin
            r_digit <= (r_digit == MAX) ? bcd_t'(0) : r_digit + bcd_t'(1);
        end
    end

    assign digit = r_digit;
    assign carry = en && (r_digit == MAX);

endmodule

// File: rtl/mmss_timer.sv
// mmss_timer -- MM:SS stopwatch with start/stop/lap control.
//   CLOCK_50 : system clock
//   RST_N    : async active-low reset
//   bus      : slave side of mmss_timer_if (tick, keys, clr in; digits/status out)
// Keys are synchronised, falling-edge detected into registered one-cycle
// press pulses. The FSM gates the 1 Hz tick into a four-digit BCD cascade;
// a lap register freezes the display while the count keeps running.
module mmss_timer
    import mmss_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input  logic         CLOCK_50,
    input  logic         RST_N,
    mmss_timer_if.slave  bus
);

    localparam bcd_t MIN_T_TOP = tens_of(MAX_MIN);
    localparam bcd_t MIN_U_TOP = units_of(MAX_MIN);
    localparam int   K_START   = 0;
    localparam int   K_LAP     = 1;

    // ---------------- button path ----------------
    logic [1:0]                  w_key;
    logic [1:0][SYNC_STAGES-1:0] r_sync;
    logic [1:0]                  r_dly;
    logic [1:0]                  r_press;
    logic                        w_start_p;
    logic                        w_lap_p;

    assign w_key = {bus.KEY_LAP, bus.KEY_START};

    // Flops reset to 1 so a released button never looks like a press.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_sync  <= '1;
            r_dly   <= '1;
            r_press <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                r_sync[k]  <= {r_sync[k][SYNC_STAGES-2:0], w_key[k]};
                r_dly[k]   <= r_sync[k][SYNC_STAGES-1];
                r_press[k] <= r_dly[k] & ~r_sync[k][SYNC_STAGES-1];
            end
        end
    end

    assign w_start_p = r_press[K_START];
    assign w_lap_p   = r_press[K_LAP];

    // ---------------- FSM ----------------
    state_t r_state, w_next;
    logic   r_running;
    logic   r_lap_hold, w_lap_hold_next;
    logic   w_lap_capture;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_running  <= 1'b0;
            r_lap_hold <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_running  <= (w_next == RUN);
            r_lap_hold <= w_lap_hold_next;
        end
    end

    // clr outranks start in every state; only PAUSE reacts to clr with a move.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!bus.clr && w_start_p) w_next = RUN;
            RUN:     if (!bus.clr && w_start_p) w_next = PAUSE;
            PAUSE:   if (bus.clr)               w_next = IDLE;
                     else if (w_start_p)        w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_lap_hold_next = r_lap_hold;
        w_lap_capture   = 1'b0;
        if (w_next != RUN) begin
            w_lap_hold_next = 1'b0;
        end else if (r_state == RUN && w_lap_p) begin
            w_lap_hold_next = ~r_lap_hold;
            w_lap_capture   = ~r_lap_hold;
        end
    end

    // ---------------- BCD cascade ----------------
    bcd_t w_sec_u, w_sec_t, w_min_u, w_min_t;
    logic w_c0, w_c1, w_c2, w_c3;
    logic w_adv;
    logic w_wrap;
    logic w_clr_min;
    logic r_wrap;

    // A tick alongside clr or start is dropped: clr zeroes, start leaves RUN.
    assign w_adv = (r_state == RUN) && bus.tick && !bus.clr && !w_start_p;

    // With a units limit of 9 the natural ripple already reaches MAX_MIN:59
    // exactly when the minute-tens carry fires; otherwise the minute digits
    // need an explicit terminal compare and clear.
    assign w_wrap = (MIN_U_TOP == MIN_U_MAX) ? w_c3
                  : (w_c1 && (w_min_u == MIN_U_TOP) && (w_min_t == MIN_T_TOP));

    assign w_clr_min = bus.clr || w_wrap;

    bcd_digit_ctr #(.MAX(SEC_U_MAX)) u_sec_u (
        .clk(CLOCK_50), .rst_n(RST_N), .en(w_adv), .clr(bus.clr),
        .digit(w_sec_u), .carry(w_c0)
    );
    bcd_digit_ctr #(.MAX(SEC_T_MAX)) u_sec_t (
        .clk(CLOCK_50), .rst_n(RST_N), .en(w_c0), .clr(bus.clr),
        .digit(w_sec_t), .carry(w_c1)
    );
    bcd_digit_ctr #(.MAX(MIN_U_MAX)) u_min_u (
        .clk(CLOCK_50), .rst_n(RST_N), .en(w_c1), .clr(w_clr_min),
        .digit(w_min_u), .carry(w_c2)
    );
    bcd_digit_ctr #(.MAX(MIN_T_TOP)) u_min_t (
        .clk(CLOCK_50), .rst_n(RST_N), .en(w_c2), .clr(w_clr_min),
        .digit(w_min_t), .carry(w_c3)
    );

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) r_wrap <= 1'b0;
        else        r_wrap <= w_wrap;
    end

    // ---------------- lap capture ----------------
    // Captures the count as it stood at the press (before any same-cycle tick).
    bcd_t [3:0] r_lap;
    bcd_t [3:0] w_cnt;

    assign w_cnt = {w_min_t, w_min_u, w_sec_t, w_sec_u};

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N)             r_lap <= '0;
        else if (w_lap_capture) r_lap <= w_cnt;
    end

    // ---------------- outputs ----------------
    assign bus.disp_min_t = r_lap_hold ? r_lap[3] : w_min_t;
    assign bus.disp_min_u = r_lap_hold ? r_lap[2] : w_min_u;
    assign bus.disp_sec_t = r_lap_hold ? r_lap[1] : w_sec_t;
    assign bus.disp_sec_u = r_lap_hold ? r_lap[0] : w_sec_u;
    assign bus.running    = r_running;
    assign bus.lap_hold   = r_lap_hold;
    assign bus.wrap       = r_wrap;

endmodule

// File: tb/tb_mmss_timer.sv
// tb_mmss_timer -- directed, table-driven bench for mmss_timer.
module tb_mmss_timer;
    import mmss_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    mmss_timer_if bus ();

    mmss_timer #(.SYNC_STAGES(2), .MAX_MIN(59)) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tick;
        logic        clr;
        int          n;
        logic [15:0] disp;
        logic        run;
        logic        wrap;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [15:0] disp_now();
        return {bus.disp_min_t, bus.disp_min_u, bus.disp_sec_t, bus.disp_sec_u};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.tick = vecs[i].tick;
            bus.clr  = vecs[i].clr;
            cycles(vecs[i].n);
            bus.tick = 1'b0;
            bus.clr  = 1'b0;
            check($sformatf("vec%0d_disp", i), 32'(disp_now()), 32'(vecs[i].disp));
            check($sformatf("vec%0d_run", i), 32'(bus.running), 32'(vecs[i].run));
            check($sformatf("vec%0d_wrap", i), 32'(bus.wrap), 32'(vecs[i].wrap));
            check($sformatf("vec%0d_lap", i), 32'(bus.lap_hold), 32'd0);
        end
    endtask

    // press held 4 cycles: pulse lands after 3, state reacts on the 4th edge
    task automatic press_lap();
        bus.KEY_LAP = 1'b0;
        cycles(4);
        bus.KEY_LAP = 1'b1;
        cycles(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int   trans;
        logic prev_run;

        n_chk = 0;
        n_err = 0;
        //          tick clr n     disp      run   wrap
        vecs[0] = '{1'b1, 1'b0, 5,    16'h0005, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 54,   16'h0059, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1,    16'h0100, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 3539, 16'h5959, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1,    16'h0000, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1,    16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 10,   16'h0010, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 133,  16'h0230, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1,    16'h0000, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 3,    16'h0003, 1'b1, 1'b0};

        rst_n         = 1'b0;
        bus.tick      = 1'b0;
        bus.clr       = 1'b0;
        bus.KEY_START = 1'b1;
        bus.KEY_LAP   = 1'b1;
        cycles(2);
        check("rst_disp", 32'(disp_now()), 32'h0);
        check("rst_run",  32'(bus.running), 32'd0);
        check("rst_lap",  32'(bus.lap_hold), 32'd0);
        check("rst_wrap", 32'(bus.wrap), 32'd0);
        rst_n = 1'b1;
        cycles(2);
        check("post_rst_disp", 32'(disp_now()), 32'h0);
        check("post_rst_run",  32'(bus.running), 32'd0);

        // start press latency
        bus.KEY_START = 1'b0;
        cycles(3);
        check("start_lat3", 32'(bus.running), 32'd0);
        cycles(1);
        check("start_lat4", 32'(bus.running), 32'd1);
        bus.KEY_START = 1'b1;
        cycles(4);
        check("start_release_run", 32'(bus.running), 32'd1);

        // count, minute carry, full wrap
        run_vecs(0, 6);

        // lap freeze at 00:10
        bus.KEY_LAP = 1'b0;
        cycles(4);
        check("lap_on_hold", 32'(bus.lap_hold), 32'd1);
        check("lap_on_disp", 32'(disp_now()), 32'h0010);
        bus.KEY_LAP = 1'b1;
        cycles(3);
        bus.tick = 1'b1;
        cycles(7);
        bus.tick = 1'b0;
        check("lap_frozen_disp", 32'(disp_now()), 32'h0010);
        check("lap_frozen_hold", 32'(bus.lap_hold), 32'd1);
        bus.KEY_LAP = 1'b0;
        cycles(4);
        check("lap_off_hold", 32'(bus.lap_hold), 32'd0);
        check("lap_off_disp", 32'(disp_now()), 32'h0017);
        bus.KEY_LAP = 1'b1;
        cycles(3);

        // clr with tick in RUN
        run_vecs(7, 9);

        // held start: one transition to PAUSE, count frozen
        bus.tick      = 1'b1;
        bus.KEY_START = 1'b0;
        trans         = 0;
        prev_run      = bus.running;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus.running !== prev_run) trans++;
            prev_run = bus.running;
            if (c == 3) begin
                check("hold_pause_run",  32'(bus.running), 32'd0);
                check("hold_pause_disp", 32'(disp_now()), 32'h0006);
            end
        end
        check("hold_transitions", 32'(trans), 32'd1);
        check("hold_end_disp", 32'(disp_now()), 32'h0006);
        check("hold_end_run",  32'(bus.running), 32'd0);
        bus.tick      = 1'b0;
        bus.KEY_START = 1'b1;
        cycles(4);
        check("release_still_pause", 32'(bus.running), 32'd0);

        // lap ignored in PAUSE
        press_lap();
        check("pause_lap_ignored", 32'(bus.lap_hold), 32'd0);

        // clr in PAUSE -> IDLE, count zeroed, ticks ignored
        bus.clr = 1'b1;
        cycles(1);
        bus.clr = 1'b0;
        check("pause_clr_disp", 32'(disp_now()), 32'h0000);
        check("pause_clr_run",  32'(bus.running), 32'd0);
        bus.tick = 1'b1;
        cycles(3);
        bus.tick = 1'b0;
        check("idle_no_count", 32'(disp_now()), 32'h0000);

        // run to 12:34 then async reset
        bus.KEY_START = 1'b0;
        cycles(4);
        check("restart_run", 32'(bus.running), 32'd1);
        bus.KEY_START = 1'b1;
        cycles(4);
        bus.tick = 1'b1;
        cycles(754);
        bus.tick = 1'b0;
        check("pre_rst_disp", 32'(disp_now()), 32'h1234);
        bus.KEY_LAP = 1'b0;
        cycles(4);
        check("pre_rst_lap", 32'(bus.lap_hold), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_disp", 32'(disp_now()), 32'h0000);
        check("async_rst_run",  32'(bus.running), 32'd0);
        check("async_rst_lap",  32'(bus.lap_hold), 32'd0);
        check("async_rst_wrap", 32'(bus.wrap), 32'd0);
        bus.KEY_LAP = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        check("after_rst_disp", 32'(disp_now()), 32'h0000);
        check("after_rst_run",  32'(bus.running), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
